// File: rtl/rv_defs.sv
// Shared RISC-V opcode constants and the long-latency classification.
// Decode uses is_long() to drive d_long_i; the scoreboard never decodes opcodes itself.
package rv_defs;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    // Loads and M-extension ops complete out of the single-cycle path.
    function automatic logic is_long(input logic [6:0] opcode, input logic [6:0] funct7);
        is_long = (opcode == OPC_LOAD) ||
                  ((opcode == OPC_OP) && (funct7 == FUNCT7_MULDIV));
    endfunction

endpackage

// File: rtl/rv_scoreboard_pkg.sv
// Types and helpers shared by the register scoreboard, its interface and bench.
package rv_scoreboard_pkg;

    localparam int NUM_REGS = 32;

    typedef logic [4:0]          reg_idx_t;
    typedef logic [2:0]          cnt_t;
    typedef logic [NUM_REGS-1:0] reg_mask_t;

    function automatic reg_mask_t onehot(input reg_idx_t idx);
        onehot = reg_mask_t'(1) << idx;
    endfunction

endpackage

// File: rtl/rv_scoreboard_if.sv
// Decode/issue/writeback signals seen by the scoreboard, plus its hazard outputs.
interface rv_scoreboard_if;
    import rv_scoreboard_pkg::*;

    logic      d_valid_i;
    reg_idx_t  d_rs1_i;
    reg_idx_t  d_rs2_i;
    reg_idx_t  d_rd_i;
    logic      d_uses_rs1_i;
    logic      d_uses_rs2_i;
    logic      d_rd_write_i;
    logic      d_long_i;
    logic      x_issue_i;
    logic      w_done_i;
    reg_idx_t  w_rd_i;
    logic      d_stall_req_o;
    reg_mask_t pending_o;
    cnt_t      count_o;
    logic      full_o;

    modport master (
        output d_valid_i, d_rs1_i, d_rs2_i, d_rd_i,
        output d_uses_rs1_i, d_uses_rs2_i, d_rd_write_i, d_long_i,
        output x_issue_i, w_done_i, w_rd_i,
        input  d_stall_req_o, pending_o, count_o, full_o
    );

    modport slave (
        input  d_valid_i, d_rs1_i, d_rs2_i, d_rd_i,
        input  d_uses_rs1_i, d_uses_rs2_i, d_rd_write_i, d_long_i,
        input  x_issue_i, w_done_i, w_rd_i,
        output d_stall_req_o, pending_o, count_o, full_o
    );

endinterface

// File: rtl/rv_scoreboard.sv
// Register scoreboard: tracks in-flight long-latency writes per register and
// raises a zero-latency decode stall for RAW, WAW and outstanding-limit hazards.
module rv_scoreboard
    import rv_scoreboard_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic           clk_i,
    input  logic           rst_i,
    rv_scoreboard_if.slave sb
);

    localparam cnt_t MAX_CNT = cnt_t'(MAX_OUTSTANDING);

    reg_mask_t r_pending;
    cnt_t      r_count;

    logic      w_issue_long;
    logic      w_done_ok;
    logic      w_at_max;
    logic      w_set_ok;
    reg_mask_t w_set_mask;
    reg_mask_t w_clr_mask;
    reg_mask_t w_bypass_mask;
    reg_mask_t w_eff_pending;
    reg_mask_t w_pending_nxt;
    cnt_t      w_count_nxt;
    logic      w_haz_rs1;
    logic      w_haz_rs2;
    logic      w_haz_rd;
    logic      w_haz_full;
    logic      w_stall;

    assign w_issue_long = sb.x_issue_i && sb.d_long_i && sb.d_rd_write_i;
    // A writeback with nothing outstanding is stray and must not touch any state.
    assign w_done_ok    = sb.w_done_i && (r_count != '0);
    assign w_at_max     = (r_count == MAX_CNT);
    assign w_set_ok     = w_issue_long && (!w_at_max || w_done_ok);

    assign w_set_mask    = (w_set_ok && (sb.d_rd_i != '0)) ? onehot(sb.d_rd_i) : '0;
    assign w_clr_mask    = (w_done_ok && (sb.w_rd_i != '0)) ? onehot(sb.w_rd_i) : '0;
    assign w_bypass_mask = sb.w_done_i ? onehot(sb.w_rd_i) : '0;
    assign w_eff_pending = r_pending & ~w_bypass_mask;

    // Set wins over clear on the same index; x0 never holds a pending bit.
    assign w_pending_nxt = ((r_pending & ~w_clr_mask) | w_set_mask) & ~reg_mask_t'(1);

    always_comb begin
        w_count_nxt = r_count;
        if (w_issue_long && w_done_ok) begin
            w_count_nxt = r_count;
        end else if (w_issue_long && !w_at_max) begin
            w_count_nxt = r_count + cnt_t'(1);
        end else if (w_done_ok) begin
            w_count_nxt = r_count - cnt_t'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pending <= '0;
            r_count   <= '0;
        end else begin
            r_pending <= w_pending_nxt;
            r_count   <= w_count_nxt;
        end
    end

    assign w_haz_rs1  = sb.d_uses_rs1_i && w_eff_pending[sb.d_rs1_i];
    assign w_haz_rs2  = sb.d_uses_rs2_i && w_eff_pending[sb.d_rs2_i];
    assign w_haz_rd   = sb.d_rd_write_i && w_eff_pending[sb.d_rd_i];
    assign w_haz_full = sb.d_long_i && w_at_max && !sb.w_done_i;

    assign w_stall = !rst_i && sb.d_valid_i &&
                     (w_haz_rs1 || w_haz_rs2 || w_haz_rd || w_haz_full);

    assign sb.d_stall_req_o = w_stall;
    assign sb.pending_o     = r_pending;
    assign sb.count_o       = r_count;
    assign sb.full_o        = w_at_max;

    // Issuing past a stall is a pipeline-control bug upstream, not something to absorb here.
    a_no_issue_while_stalled: assert property (
        @(posedge clk_i) disable iff (rst_i) !(sb.x_issue_i && w_stall)
    );

endmodule

// File: tb/tb_rv_scoreboard.sv
// Directed scoreboard bench: stall checked mid-cycle, post-edge state queued and compared.
module tb_rv_scoreboard;
    import rv_defs::*;
    import rv_scoreboard_pkg::*;

    localparam int MAX = 2;

    typedef struct {
        string     tag;
        reg_mask_t pend;
        cnt_t      cnt;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    logic lng;
    exp_t exp_q[$];

    rv_scoreboard_if sb_if ();

    rv_scoreboard #(.MAX_OUTSTANDING(MAX)) u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .sb    (sb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic reg_mask_t b(input int n);
        b = reg_mask_t'(1) << n;
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic drive(input logic v, input reg_idx_t rs1, input reg_idx_t rs2,
                         input reg_idx_t rd, input logic u1, input logic u2,
                         input logic rdw, input logic lg, input logic iss,
                         input logic wd, input reg_idx_t wrd);
        sb_if.d_valid_i    = v;
        sb_if.d_rs1_i      = rs1;
        sb_if.d_rs2_i      = rs2;
        sb_if.d_rd_i       = rd;
        sb_if.d_uses_rs1_i = u1;
        sb_if.d_uses_rs2_i = u2;
        sb_if.d_rd_write_i = rdw;
        sb_if.d_long_i     = lg;
        sb_if.x_issue_i    = iss;
        sb_if.w_done_i     = wd;
        sb_if.w_rd_i       = wrd;
    endtask

    task automatic issue_long(input reg_idx_t rd);
        drive(1'b1, 5'd0, 5'd0, rd, 1'b0, 1'b0, 1'b1, lng, 1'b1, 1'b0, 5'd0);
    endtask

    task automatic wb(input reg_idx_t wrd);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, wrd);
    endtask

    // Inputs are already applied (just after a rising edge); check stall, then post-edge state.
    task automatic cyc(input string tag, input logic exp_stall,
                       input reg_mask_t exp_pend, input cnt_t exp_cnt);
        exp_t e;
        #2;
        check({tag, ".stall"}, 32'(sb_if.d_stall_req_o), 32'(exp_stall));
        e.tag  = tag;
        e.pend = exp_pend;
        e.cnt  = exp_cnt;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, ".queue"}, 32'(0), 32'(1));
        end else begin
            e = exp_q.pop_front();
            check({e.tag, ".pending"}, sb_if.pending_o, e.pend);
            check({e.tag, ".count"}, 32'(sb_if.count_o), 32'(e.cnt));
            check({e.tag, ".full"}, 32'(sb_if.full_o), 32'(int'(e.cnt) == MAX));
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        lng      = is_long(OPC_LOAD, 7'd0);
        rst      = 1'b1;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        @(posedge clk);
        #1;
        cyc("reset", 1'b0, '0, 3'd0);
        rst = 1'b0;

        // load-use on x5
        issue_long(5'd5);                                                        cyc("lu_issue", 1'b0, b(5), 3'd1);
        drive(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0); cyc("lu_hold0", 1'b1, b(5), 3'd1);
        cyc("lu_hold1", 1'b1, b(5), 3'd1);
        drive(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5); cyc("lu_release", 1'b0, '0, 3'd0);

        // x0 destination is counted but never tracked
        issue_long(5'd0);                                                        cyc("x0_issue", 1'b0, '0, 3'd1);
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0); cyc("x0_use", 1'b0, '0, 3'd1);
        wb(5'd0);                                                                cyc("x0_wb", 1'b0, '0, 3'd0);

        // outstanding limit
        issue_long(5'd3);                                                        cyc("full_a", 1'b0, b(3), 3'd1);
        issue_long(5'd4);                                                        cyc("full_b", 1'b0, b(3) | b(4), 3'd2);
        drive(1'b1, 5'd0, 5'd0, 5'd10, 1'b0, 1'b0, 1'b1, lng, 1'b0, 1'b0, 5'd0); cyc("full_stall", 1'b1, b(3) | b(4), 3'd2);
        drive(1'b1, 5'd0, 5'd0, 5'd10, 1'b0, 1'b0, 1'b1, lng, 1'b1, 1'b1, 5'd3); cyc("full_release", 1'b0, b(4) | b(10), 3'd2);
        wb(5'd4);                                                                cyc("drain_4", 1'b0, b(10), 3'd1);
        wb(5'd10);                                                               cyc("drain_10", 1'b0, '0, 3'd0);

        // set/clear collision on x7
        issue_long(5'd7);                                                        cyc("col_first", 1'b0, b(7), 3'd1);
        drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1, lng, 1'b1, 1'b1, 5'd7);  cyc("col_same", 1'b0, b(7), 3'd1);
        wb(5'd7);                                                                cyc("col_drain", 1'b0, '0, 3'd0);

        // WAW on x9, rs1 field matches but is unused
        issue_long(5'd9);                                                        cyc("waw_issue", 1'b0, b(9), 3'd1);
        drive(1'b1, 5'd9, 5'd0, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0); cyc("waw_hold0", 1'b1, b(9), 3'd1);
        cyc("waw_hold1", 1'b1, b(9), 3'd1);
        drive(1'b1, 5'd9, 5'd0, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9); cyc("waw_release", 1'b0, '0, 3'd0);

        // rs2 hazard and d_valid gating
        issue_long(5'd12);                                                       cyc("rs2_issue", 1'b0, b(12), 3'd1);
        drive(1'b1, 5'd12, 5'd12, 5'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0); cyc("rs2_stall", 1'b1, b(12), 3'd1);
        drive(1'b0, 5'd12, 5'd12, 5'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0); cyc("rs2_novalid", 1'b0, b(12), 3'd1);
        wb(5'd12);                                                               cyc("rs2_drain", 1'b0, '0, 3'd0);

        // reset while two ops are in flight, then a stray writeback
        issue_long(5'd20);                                                       cyc("rst_a", 1'b0, b(20), 3'd1);
        issue_long(5'd21);                                                       cyc("rst_b", 1'b0, b(20) | b(21), 3'd2);
        rst = 1'b1;
        drive(1'b1, 5'd20, 5'd0, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0); cyc("rst_mid", 1'b0, '0, 3'd0);
        rst = 1'b0;
        wb(5'd21);                                                               cyc("rst_stray_wb", 1'b0, '0, 3'd0);
        drive(1'b1, 5'd20, 5'd0, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0); cyc("rst_no_haz", 1'b0, '0, 3'd0);

        // bypass only releases the matching register
        issue_long(5'd15);                                                       cyc("byp_a", 1'b0, b(15), 3'd1);
        issue_long(5'd14);                                                       cyc("byp_b", 1'b0, b(15) | b(14), 3'd2);
        drive(1'b1, 5'd15, 5'd0, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd14); cyc("byp_other", 1'b1, b(15), 3'd1);
        drive(1'b1, 5'd15, 5'd0, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd15); cyc("byp_match", 1'b0, '0, 3'd0);

        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/rv_scoreboard.md
RV_SCOREBOARD -- requirements
Module: rv_scoreboard

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 2, giving the maximum number of in-flight long-latency writes (loads and multi-cycle ops); legal range 1..7.
REQ-002 SHALL have: clk_i  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have: rst_i  in  1  reset, synchronous and active-high.
REQ-004 SHALL have: d_valid_i  in  1  decode holds a valid instruction.
REQ-005 SHALL have: d_rs1_i, d_rs2_i, d_rd_i  in  5 each  decode source and destination register indices.
REQ-006 SHALL have: d_uses_rs1_i, d_uses_rs2_i, d_rd_write_i, d_long_i  in  1 each  operand-use flags, destination-write flag, long-latency flag.
REQ-007 SHALL have: x_issue_i  in  1  decode instruction advances to execute this cycle (not stalled, not killed).
REQ-008 SHALL have: w_done_i  in  1, w_rd_i  in  5  long-latency result written back this cycle to w_rd_i.
REQ-009 SHALL have: d_stall_req_o  out  1  decode must hold.
REQ-010 SHALL have: pending_o  out  32  per-register in-flight mask.
REQ-011 SHALL have: count_o  out  3  number of in-flight long ops.
REQ-012 SHALL have: full_o  out  1  count_o == MAX_OUTSTANDING.

Function
REQ-013 SHALL set pending bit d_rd_i on a rising edge when x_issue_i && d_long_i && d_rd_write_i && d_rd_i != 0.
REQ-014 SHALL clear pending bit w_rd_i on a rising edge when w_done_i && w_rd_i != 0.
REQ-015 SHALL give set priority over clear when both target the same index in one cycle; the bit stays 1.
REQ-016 SHALL hold pending_o[0] at 0 permanently.
REQ-017 SHALL increment count_o on a qualifying issue (REQ-013, including rd == 0 with d_long_i), decrement on w_done_i, and leave it unchanged when both occur in the same cycle.
REQ-018 SHALL saturate count_o: no increment above MAX_OUTSTANDING, no decrement below 0. An underflowing w_done_i is ignored for both count_o and the mask.
REQ-019 SHALL form the hazard from pending_o with same-cycle bypass: effective bit = pending[i] && !(w_done_i && w_rd_i == i).
REQ-020 SHALL assert d_stall_req_o combinationally when d_valid_i and any of the following holds: (d_uses_rs1_i and rs1 effective-pending); (d_uses_rs2_i and rs2 effective-pending); (d_rd_write_i and rd effective-pending, the WAW case); (d_long_i and full_o and !w_done_i).
REQ-021 SHALL keep d_stall_req_o at 0 when d_valid_i is 0, and for register index 0.
REQ-022 SHALL have zero-cycle stall-decision latency; a stalled instruction SHALL be released in the cycle its blocking writeback arrives, via the bypass.
REQ-023 SHALL NOT change state on pipeline kill; in-flight ops still retire through w_done_i.
REQ-024 SHALL treat x_issue_i asserted together with d_stall_req_o as a protocol error; it is checked by assertion and is not handled.

Reset
REQ-025 SHALL drive pending_o = 0, count_o = 0 and full_o = 0 in the cycle after rst_i is sampled high.
REQ-026 SHALL, when reset occurs mid-operation, discard all in-flight tracking; writebacks arriving after reset are ignored per REQ-018.
REQ-027 SHALL keep d_stall_req_o at 0 while rst_i is high.

Structure
REQ-028 SHALL take the opcode constants and the long-latency classification (LOAD, multiply/divide) from the shared definitions file, rv_defs. The scoreboard SHALL NOT decode instructions itself.
REQ-029 SHALL be implemented as a single module with no sub-modules; the 32-entry mask and the counter are flat registers.

Verification
REQ-030 SHALL cover load-use: issue a long op with rd = 5; next instruction uses rs1 = 5 -> d_stall_req_o = 1 until w_done_i with w_rd_i = 5; stall drops in that same cycle; pending_o[5] = 0 on the next edge.
REQ-031 SHALL cover x0: a long issue with rd = 0, then an instruction using rs1 = 0 -> no stall; pending_o stays 0; count_o goes 0 -> 1.
REQ-032 SHALL cover full: with MAX_OUTSTANDING = 2, two long issues (rd = 3, rd = 4), then a third long op -> stall with full_o = 1; w_done_i for rd = 3 in the same cycle -> stall drops; count_o remains 2.
REQ-033 SHALL cover set/clear collision: in one cycle issue long rd = 7 and w_done_i with w_rd_i = 7 -> pending_o[7] = 1 and count_o unchanged.
REQ-034 SHALL cover WAW: pending rd = 9, decode writes rd = 9 without reading it -> stall until the writeback.
REQ-035 SHALL cover reset mid-flight: with count_o = 2, pulse rst_i -> pending_o = 0 and count_o = 0; a later stray w_done_i -> count_o remains 0.
